vdp_bus_sync: RTL and testbench

//  Host-side front end for the VDP CPU interface. Samples the asynchronous CPU I/O strobes, address and data

---
 rtl/vdp_pkg.sv | 25 ++
 rtl/vdp_bus_fifo.sv | 63 ++++++
 rtl/vdp_bus_sync.sv | 225 ++++++++++++++++++++++
 tb/tb_vdp_bus_sync.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP CPU bus front end.
//   PORT_VRAM / PORT_VDP : port-select encoding carried with each queued write and read request
//   vdp_state_e          : bus sequencer states
//   port_sel()           : maps a decoded I/O address onto the port-select encoding
`timescale 1ns/1ps
package vdp_pkg;

  localparam logic PORT_VRAM = 1'b0;
  localparam logic PORT_VDP  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_HOLD = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RD_HOLD = 3'd4
  } vdp_state_e;

  // Only the register port address selects PORT_VDP; anything else maps to VRAM
  // (callers gate with their own address-match first).
  function automatic logic port_sel(input logic [7:0] addr, input logic [7:0] vdp_addr);
    return (addr == vdp_addr) ? PORT_VDP : PORT_VRAM;
  endfunction

endpackage

// File: rtl/vdp_bus_fifo.sv
// Generic first-word-fall-through FIFO with registered storage.
//   clk_i, rst_n_i : clock, asynchronous active-low reset (flushes pointers and storage)
//   push_i, data_i : write strobe and data; a push into a full FIFO is accepted only with a pop
//   pop_i          : consume the head entry (ignored when empty)
//   valid_o        : head entry present
//   full_o         : no free entry
//   data_o         : head entry
`timescale 1ns/1ps
module vdp_bus_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             empty_s;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  // The extra top pointer bit distinguishes full from empty when the indices match.
  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop_s  = pop_i & ~empty_s;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push_s = push_i & (~full_s | do_pop_s);

  // Storage and pointer update; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  assign valid_o = ~empty_s;
  assign full_o  = full_s;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/vdp_bus_sync.sv
// CPU I/O front end for the VDP: synchronises and de-glitches the CPU strobes, decodes the
// VRAM and register ports, queues writes in a FWFT FIFO and sequences reads.
//   clk40m, rst_n          : 40 MHz clock, asynchronous active-low reset
//   cpu_a, cpu_d_i         : CPU address / write data (asynchronous, stable across a strobe)
//   cpu_in_n, cpu_out_n    : CPU read / write strobes, active low, asynchronous
//   cpu_d_o, cpu_d_oe      : read data and its tristate enable
//   wr_valid/ready/port/data : write queue head towards vdp_cpu
//   rd_req, rd_port        : read request pulse and its port (port held until the next request)
//   rd_valid, rd_data      : read response from vdp_cpu
//   ovf                    : sticky write-dropped flag, cleared only by reset
`timescale 1ns/1ps
module vdp_bus_sync
  import vdp_pkg::*;
#(
  parameter logic [7:0] CPU_VRAM_PORT = 8'h01,
  parameter logic [7:0] CPU_VDP_PORT  = 8'h02,
  parameter int         SYNC_STAGES   = 2,
  parameter int         FILT_CYCLES   = 3,
  parameter int         FIFO_DEPTH    = 4
) (
  input  logic       clk40m,
  input  logic       rst_n,
  input  logic [7:0] cpu_a,
  input  logic [7:0] cpu_d_i,
  output logic [7:0] cpu_d_o,
  output logic       cpu_d_oe,
  input  logic       cpu_in_n,
  input  logic       cpu_out_n,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic       wr_port,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic       rd_port,
  input  logic       rd_valid,
  input  logic [7:0] rd_data,
  output logic       ovf
);

  localparam logic [2:0] FILT_LAST = 3'(FILT_CYCLES - 1);

  // Index 0 is the read strobe, index 1 the write strobe.
  logic [1:0] strobe_n_s;
  logic [1:0] qual_s;
  logic [1:0] rise_s;

  assign strobe_n_s = {cpu_out_n, cpu_in_n};

  for (genvar g = 0; g < 2; g++) begin : g_strobe
    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             cnt_q;
    logic                   qual_q;
    logic                   rise_q;
    logic                   active_s;

    assign active_s = ~sync_q[SYNC_STAGES-1];

    // Synchroniser plus saturating filter. The qualified level starts asserted so a strobe
    // already low at reset release must first be seen high before it can qualify again;
    // rise_q marks only a genuine inactive-to-active transition.
    always_ff @(posedge clk40m or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '1;
        cnt_q  <= 3'd0;
        qual_q <= 1'b1;
        rise_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n_s[g]};
        rise_q <= 1'b0;
        if (active_s != qual_q) begin
          if (cnt_q == FILT_LAST) begin
            qual_q <= active_s;
            cnt_q  <= 3'd0;
            rise_q <= active_s;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end else begin
          cnt_q <= 3'd0;
        end
      end
    end

    assign qual_s[g] = qual_q;
    assign rise_s[g] = rise_q;
  end

  logic in_qual_s, out_qual_s, in_rise_s, out_rise_s;
  assign in_qual_s  = qual_s[0];
  assign out_qual_s = qual_s[1];
  assign in_rise_s  = rise_s[0];
  assign out_rise_s = rise_s[1];

  vdp_state_e state_q;
  logic [7:0] cap_a_q;
  logic [7:0] cap_d_q;
  logic       rd_req_q;
  logic       rd_port_q;
  logic [7:0] d_o_q;
  logic       oe_q;
  logic       ovf_q;

  logic       match_s;
  logic       port_s;
  logic       push_s;
  logic       pop_s;
  logic       ovf_set_s;
  logic       fifo_valid_s;
  logic       fifo_full_s;
  logic [8:0] fifo_dout_s;

  assign match_s = (cap_a_q == CPU_VRAM_PORT) || (cap_a_q == CPU_VDP_PORT);
  assign port_s  = port_sel(cap_a_q, CPU_VDP_PORT);
  assign pop_s   = fifo_valid_s & wr_ready;

  // Write acceptance: a full FIFO still takes the push when the head is popped in the same cycle.
  always_comb begin
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    if ((state_q == ST_IDLE) && out_rise_s && match_s) begin
      if (!fifo_full_s || pop_s) begin
        push_s = 1'b1;
      end else begin
        ovf_set_s = 1'b1;
      end
    end else begin
      push_s    = 1'b0;
      ovf_set_s = 1'b0;
    end
  end

  // Bus sequencer with registered CPU-side outputs. Address/data are sampled every idle
  // cycle; by the time a strobe qualifies the CPU has held them stable for several cycles,
  // so the copy used on the qualifying cycle is clean.
  always_ff @(posedge clk40m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cap_a_q   <= 8'h00;
      cap_d_q   <= 8'h00;
      rd_req_q  <= 1'b0;
      rd_port_q <= 1'b0;
      d_o_q     <= 8'h00;
      oe_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      rd_req_q <= 1'b0;
      if (ovf_set_s) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          cap_a_q <= cpu_a;
          cap_d_q <= cpu_d_i;
          oe_q    <= 1'b0;
          // A write qualifying together with a read takes precedence; the read is dropped.
          if (out_rise_s) begin
            if (match_s) begin
              state_q <= ST_WR_HOLD;
            end
          end else if (in_rise_s && match_s) begin
            state_q <= ST_RD_WAIT;
          end
        end
        ST_WR_HOLD: begin
          if (!out_qual_s) begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          // Earlier queued writes (address setup) must drain before the read is issued.
          if (!in_qual_s) begin
            state_q <= ST_IDLE;
          end else if (!fifo_valid_s) begin
            rd_req_q  <= 1'b1;
            rd_port_q <= port_s;
            state_q   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (!in_qual_s) begin
            state_q <= ST_IDLE;
          end else if (rd_valid) begin
            d_o_q   <= rd_data;
            oe_q    <= 1'b1;
            state_q <= ST_RD_HOLD;
          end
        end
        ST_RD_HOLD: begin
          if (!in_qual_s) begin
            oe_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          oe_q    <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  vdp_bus_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk40m),
    .rst_n_i (rst_n),
    .push_i  (push_s),
    .data_i  ({port_s, cap_d_q}),
    .pop_i   (pop_s),
    .valid_o (fifo_valid_s),
    .full_o  (fifo_full_s),
    .data_o  (fifo_dout_s)
  );

  assign wr_valid = fifo_valid_s;
  assign wr_port  = fifo_dout_s[8];
  assign wr_data  = fifo_dout_s[7:0];
  assign rd_req   = rd_req_q;
  assign rd_port  = rd_port_q;
  assign cpu_d_o  = d_o_q;
  assign cpu_d_oe = oe_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_vdp_bus_sync.sv
`timescale 1ns/1ps
module tb_vdp_bus_sync;

  localparam int SYNC  = 2;
  localparam int FILT  = 3;
  localparam int DEPTH = 4;

  logic       clk40m = 1'b0;
  logic       rst_n;
  logic [7:0] cpu_a, cpu_d_i, cpu_d_o, wr_data, rd_data;
  logic       cpu_d_oe, cpu_in_n, cpu_out_n, wr_valid, wr_ready, wr_port;
  logic       rd_req, rd_port, rd_valid, ovf;

  always #12.5 clk40m = ~clk40m;

  vdp_bus_sync #(
    .CPU_VRAM_PORT (8'h01),
    .CPU_VDP_PORT  (8'h02),
    .SYNC_STAGES   (SYNC),
    .FILT_CYCLES   (FILT),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk40m    (clk40m),
    .rst_n     (rst_n),
    .cpu_a     (cpu_a),
    .cpu_d_i   (cpu_d_i),
    .cpu_d_o   (cpu_d_o),
    .cpu_d_oe  (cpu_d_oe),
    .cpu_in_n  (cpu_in_n),
    .cpu_out_n (cpu_out_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_port   (wr_port),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_port   (rd_port),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .ovf       (ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: queue of expected {port,data} entries and the expected sticky flag.
  logic [8:0] exp_q[$];
  logic       ovf_exp = 1'b0;

  // Event counters observed on the clock edge.
  int rd_req_cnt  = 0;
  int pop_cnt     = 0;
  int oe_cycles   = 0;
  int pops_at_req = 0;

  always @(posedge clk40m) begin
    if (rd_req) begin
      rd_req_cnt  <= rd_req_cnt + 1;
      pops_at_req <= pop_cnt;
    end
    if (wr_valid && wr_ready) pop_cnt <= pop_cnt + 1;
    if (cpu_d_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_hit(input logic [7:0] a);
    return (a == 8'h01) || (a == 8'h02);
  endfunction

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (addr_hit(a)) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({(a == 8'h02), d});
      else ovf_exp = 1'b1;
    end
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input int cycles);
    @(negedge clk40m);
    cpu_a = a;
    cpu_d_i = d;
    @(negedge clk40m);
    cpu_out_n = 1'b0;
    repeat (cycles) @(negedge clk40m);
    cpu_out_n = 1'b1;
    repeat (12) @(negedge clk40m);
    model_write(a, d);
  endtask

  task automatic drain(input string tag);
    int guard;
    while (exp_q.size() > 0) begin
      guard = 0;
      while (!wr_valid && guard < 30) begin
        @(negedge clk40m);
        guard++;
      end
      check({tag, "_valid"}, 32'(wr_valid), 32'd1);
      check({tag, "_head"}, 32'({wr_port, wr_data}), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      wr_ready = 1'b1;
      @(negedge clk40m);
      wr_ready = 1'b0;
    end
    check({tag, "_empty"}, 32'(wr_valid), 32'd0);
  endtask

  task automatic wait_rd(input int target);
    int g;
    g = 0;
    while (rd_req_cnt < target && g < 40) begin
      @(negedge clk40m);
      g++;
    end
    check("rd_req_seen", 32'(rd_req_cnt >= target), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, rq0, oe0, pb, cyc, r;
    logic [7:0] a, d;

    // 1. Reset values, strobe held low through reset release
    rst_n = 1'b0; cpu_out_n = 1'b0; cpu_in_n = 1'b1; cpu_a = 8'h01; cpu_d_i = 8'($urandom);
    wr_ready = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
    repeat (3) @(negedge clk40m);
    check("reset_outs", 32'({cpu_d_o, cpu_d_oe, wr_valid, wr_port, wr_data, rd_req, rd_port, ovf}), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk40m);
    check("no_push_low_at_release", 32'(wr_valid), 32'd0);
    cpu_out_n = 1'b1;
    repeat (15) @(negedge clk40m);
    check("no_push_on_release", 32'(wr_valid), 32'd0);
    cpu_write(8'h01, 8'($urandom), 8);
    drain("t1");

    // 2. Single write latency, then a glitch
    d = 8'hA5;
    @(negedge clk40m);
    cpu_a = 8'h01; cpu_d_i = d;
    @(negedge clk40m);
    cpu_out_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk40m);
      if (wr_valid && lat == 0) lat = i;
    end
    cpu_out_n = 1'b1;
    repeat (12) @(negedge clk40m);
    model_write(8'h01, d);
    check("wr_latency", 32'(lat >= 1 && lat <= SYNC + FILT + 2), 32'd1);
    drain("t2");
    @(negedge clk40m);
    cpu_a = 8'h01;
    cpu_out_n = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clk40m);
    cpu_out_n = 1'b1;
    repeat (15) @(negedge clk40m);
    check("glitch_ignored", 32'(wr_valid), 32'd0);

    // Random writes, including non-decoded addresses
    for (int k = 0; k < 3; k++) begin
      r = int'($urandom_range(0, 2));
      a = (r == 0) ? 8'h01 : (r == 1) ? 8'h02 : 8'($urandom);
      cyc = int'($urandom_range(6, 10));
      cpu_write(a, 8'($urandom), cyc);
    end
    drain("rnd");
    check("ovf_clear", 32'(ovf), 32'(ovf_exp));

    // 3. Overflow
    for (int k = 0; k < 5; k++) cpu_write(8'h02, 8'($urandom), 8);
    check("ovf_set", 32'(ovf), 32'(ovf_exp));
    drain("t3");
    check("ovf_sticky", 32'(ovf), 32'd1);

    // 4. Read ordered behind queued writes
    rq0 = rd_req_cnt; pb = pop_cnt;
    cpu_write(8'h02, 8'h00, 8);
    cpu_write(8'h02, 8'h40, 8);
    @(negedge clk40m);
    cpu_a = 8'h01;
    cpu_in_n = 1'b0;
    repeat (20) @(negedge clk40m);
    check("rd_blocked_by_fifo", 32'(rd_req_cnt - rq0), 32'd0);
    drain("t4");
    wait_rd(rq0 + 1);
    check("rd_after_pops", 32'(pops_at_req - pb), 32'd2);
    check("rd_port_vram", 32'(rd_port), 32'd0);
    rd_data = 8'h3C; rd_valid = 1'b1;
    @(negedge clk40m);
    rd_valid = 1'b0;
    check("oe_on", 32'(cpu_d_oe), 32'd1);
    check("d_o", 32'(cpu_d_o), 32'h3C);
    repeat (5) @(negedge clk40m);
    check("oe_hold", 32'(cpu_d_oe), 32'd1);
    cpu_in_n = 1'b1;
    repeat (4) @(negedge clk40m);
    check("oe_until_release", 32'(cpu_d_oe), 32'd1);
    repeat (4) @(negedge clk40m);
    check("oe_off", 32'(cpu_d_oe), 32'd0);
    repeat (6) @(negedge clk40m);

    // 5a. Read of an undecoded port
    rq0 = rd_req_cnt; oe0 = oe_cycles;
    @(negedge clk40m);
    cpu_a = 8'h05;
    cpu_in_n = 1'b0;
    repeat (15) @(negedge clk40m);
    cpu_in_n = 1'b1;
    repeat (12) @(negedge clk40m);
    check("rd_undecoded", 32'(rd_req_cnt - rq0), 32'd0);
    check("oe_undecoded", 32'(oe_cycles - oe0), 32'd0);

    // 5b. Read aborted before data, late data ignored
    rq0 = rd_req_cnt; oe0 = oe_cycles;
    @(negedge clk40m);
    cpu_a = 8'h02;
    cpu_in_n = 1'b0;
    wait_rd(rq0 + 1);
    check("rd_port_vdp", 32'(rd_port), 32'd1);
    cpu_in_n = 1'b1;
    repeat (12) @(negedge clk40m);
    rd_data = 8'($urandom); rd_valid = 1'b1;
    @(negedge clk40m);
    rd_valid = 1'b0;
    repeat (8) @(negedge clk40m);
    check("abort_no_drive", 32'(oe_cycles - oe0), 32'd0);
    check("abort_one_req", 32'(rd_req_cnt - rq0), 32'd1);
    check("rd_port_held", 32'(rd_port), 32'd1);

    // 6. Simultaneous strobes: write wins
    rq0 = rd_req_cnt;
    d = 8'($urandom);
    @(negedge clk40m);
    cpu_a = 8'h01; cpu_d_i = d;
    @(negedge clk40m);
    cpu_in_n = 1'b0; cpu_out_n = 1'b0;
    repeat (12) @(negedge clk40m);
    cpu_in_n = 1'b1; cpu_out_n = 1'b1;
    repeat (12) @(negedge clk40m);
    model_write(8'h01, d);
    check("both_no_rd", 32'(rd_req_cnt - rq0), 32'd0);
    drain("t6");

    // 6b. Asynchronous reset during RD_HOLD
    rq0 = rd_req_cnt;
    @(negedge clk40m);
    cpu_a = 8'h01;
    cpu_in_n = 1'b0;
    wait_rd(rq0 + 1);
    d = 8'($urandom);
    rd_data = d; rd_valid = 1'b1;
    @(negedge clk40m);
    rd_valid = 1'b0;
    check("hold_oe_on", 32'(cpu_d_oe), 32'd1);
    check("hold_d_o", 32'(cpu_d_o), 32'(d));
    #5 rst_n = 1'b0;
    #1;
    check("arst_oe", 32'(cpu_d_oe), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    exp_q.delete(); ovf_exp = 1'b0;
    cpu_in_n = 1'b1;
    repeat (2) @(negedge clk40m);
    rst_n = 1'b1;
    repeat (10) @(negedge clk40m);

    // Reset flushes a pending FIFO entry
    cpu_write(8'h02, 8'($urandom), 8);
    check("pending_entry", 32'(wr_valid), 32'(exp_q.size() > 0));
    #5 rst_n = 1'b0;
    #1;
    check("arst_flush", 32'(wr_valid), 32'd0);
    exp_q.delete();
    @(negedge clk40m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk40m);
    check("final_ovf", 32'(ovf), 32'(ovf_exp));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
